bip_debug_ctrl: RTL
===================

# bip_debug_ctrl

Run/step controller for the BIP processor, driven from the UART link. It decodes single-byte commands from the UART receiver and gates the BIP clock-enable to run until HALT or to execute one instruction. On completion it sends a 6-byte status report (accumulator, instruction, cycle count) to the UART transmitter, one byte per transmit handshake. It sits between the UART rx/tx pair and the BIP core, and replaces free-running execution with host-controlled execution.

## Interface
- NB_DATA, 16, width of accumulator and instruction words; must be 16.
- LOG2_N_INSMEM_ADDR, 11, width of cycle counter; must be ≤16.
- NB_DATATX, 8, UART byte width; must be 8.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  NB_DATATX  received command byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data.
- i_halt  in  1  level; BIP has executed HALT.
- i_acc  in  NB_DATA  BIP accumulator.
- i_instruction  in  NB_DATA  BIP current instruction.
- i_tx_done  in  1  one-cycle pulse: UART transmitter finished the current byte.
- o_bip_enable  out  1  BIP clock-enable.
- o_bip_rst  out  1  one-cycle soft-reset pulse to the BIP.
- o_tx_data  out  NB_DATATX  byte to transmit.
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data.
- o_nclock  out  LOG2_N_INSMEM_ADDR  count of enabled BIP cycles.
- o_busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, RUN, STEP, TX_SEND and TX_WAIT.
- Commands are decoded only in IDLE, except 'X' (see below). Any other byte is ignored.
  - 0x52 'R': go to RUN.
  - 0x53 'S': go to STEP.
  - 0x58 'X': pulse o_bip_rst, clear o_nclock, stay in IDLE.
- o_bip_enable = ((state==RUN) | (state==STEP)) & ~i_halt. This is combinational, so the BIP is never enabled while halted.
- RUN: stay while i_halt=0. When i_halt is sampled 1, go to TX_SEND.
- RUN with an 'X' received: pulse o_bip_rst, clear o_nclock, go to IDLE, send no report.
- STEP: lasts exactly one cycle, then TX_SEND.
- 'R' or 'S' issued while i_halt=1 gives zero enabled cycles, followed by a report.
- Bytes received in STEP, TX_SEND or TX_WAIT are dropped, including 'X'.
- o_nclock increments on every cycle with o_bip_enable=1. It saturates at all-ones and never wraps.
- Report snapshot:
  - On the transition into TX_SEND from RUN or STEP, latch i_acc, i_instruction and o_nclock. The nclock value is zero-extended to 16 bits and includes the increment made in the final enabled cycle.
  - Bytes are sent MSB first, in index order 0..5: acc[15:8], acc[7:0], instr[15:8], instr[7:0], nclk[15:8], nclk[7:0].
- TX_SEND: o_tx_start=1 for one cycle with o_tx_data = byte[idx], then go to TX_WAIT.
- TX_WAIT:
  - o_tx_data is held stable.
  - On i_tx_done: if idx==5, go to IDLE and clear idx; otherwise increment idx and go to TX_SEND.
  - i_tx_done outside TX_WAIT is ignored.

## Timing
- Reset values: state IDLE, idx 0, snapshot 0. All outputs are 0: o_bip_enable, o_bip_rst, o_tx_data, o_tx_start, o_nclock, o_busy.
- Asserting i_rst mid-operation aborts immediately. No further o_tx_start is issued.
- 'S' with i_rx_done at edge T:
  - STEP during cycle T+1, with o_bip_enable=1 when i_halt=0.
  - First o_tx_start during cycle T+2.
- 'R' at edge T: o_bip_enable first high in cycle T+1.
- 'X' at edge T: o_bip_rst high during cycle T+1. o_nclock reads 0 from T+1.
- Byte spacing: the next o_tx_start comes one cycle after the i_tx_done pulse.
- Report length: 6 × (tx time + 2 cycles) after the snapshot.
- o_busy is registered from state. It is high from the cycle after command acceptance until the cycle after the last i_tx_done.

## Test plan
- Reset, then 'S' with i_halt=0, i_acc=0x1234, i_instruction=0xABCD:
  - One enable cycle, o_nclock=1.
  - Report 12 34 AB CD 00 01, each byte released only after i_tx_done.
- 'R', with i_halt raised after 10 enabled cycles:
  - o_bip_enable is high for exactly 10 cycles.
  - Report nclk bytes are 00 0A; o_nclock stays at 10 afterwards.
- 'R' while i_halt=1: no enable cycles; report carries the unchanged nclock.
- 'X' sent during RUN:
  - Single o_bip_rst pulse, o_nclock=0, return to IDLE.
  - No o_tx_start.
- 'S' and 'R' sent while in TX_WAIT: both are ignored.
  - After the report completes, o_busy=0 and no further enable occurs.
- Force o_nclock to 0x7FE, then run 3 cycles: count saturates at 0x7FF and the report sends 07 FF.

Source files
------------

// File: rtl/bip_debug_ctrl_if.sv
// Bundle of the UART-side and BIP-side signals of the run/step debug controller.
// The controller uses the slave modport; the host/core model drives through master.
`timescale 1ns/1ps
interface bip_debug_ctrl_if #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int NB_DATATX          = 8
);
  // Handshakes are single-cycle pulses, not valid/ready pairs: i_rx_done qualifies
  // i_rx_data for one cycle, o_tx_start launches o_tx_data for one cycle, and
  // i_tx_done acknowledges that byte. o_tx_data stays stable until that acknowledge.
  logic [NB_DATATX-1:0]          i_rx_data;
  logic                          i_rx_done;
  logic                          i_halt;
  logic [NB_DATA-1:0]            i_acc;
  logic [NB_DATA-1:0]            i_instruction;
  logic                          i_tx_done;
  logic                          o_bip_enable;
  logic                          o_bip_rst;
  logic [NB_DATATX-1:0]          o_tx_data;
  logic                          o_tx_start;
  logic [LOG2_N_INSMEM_ADDR-1:0] o_nclock;
  logic                          o_busy;
  logic [2:0]                    o_dbg_state;

  modport master (
    output i_rx_data, i_rx_done, i_halt, i_acc, i_instruction, i_tx_done,
    input  o_bip_enable, o_bip_rst, o_tx_data, o_tx_start, o_nclock, o_busy, o_dbg_state
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_halt, i_acc, i_instruction, i_tx_done,
    output o_bip_enable, o_bip_rst, o_tx_data, o_tx_start, o_nclock, o_busy, o_dbg_state
  );
endinterface

// File: rtl/bip_debug_ctrl.sv
// Host-controlled run/step gate for the BIP core with a 6-byte status report
// (acc, instruction, cycle count) returned over the UART transmitter.
`timescale 1ns/1ps
module bip_debug_ctrl #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int NB_DATATX          = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bip_debug_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    TX_SEND = 3'd3,
    TX_WAIT = 3'd4
  } state_t;

  localparam logic [NB_DATATX-1:0] CMD_RUN   = 8'h52;
  localparam logic [NB_DATATX-1:0] CMD_STEP  = 8'h53;
  localparam logic [NB_DATATX-1:0] CMD_RESET = 8'h58;

  state_t                        state_q, state_d;
  logic [2:0]                    idx_q, idx_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] nclk_q, nclk_d;
  logic [NB_DATA-1:0]            acc_q, acc_d;
  logic [NB_DATA-1:0]            instr_q, instr_d;
  logic [15:0]                   nclk16_q, nclk16_d;
  logic                          bip_rst_q, bip_rst_d;
  logic                          tx_start_q;
  logic [NB_DATATX-1:0]          tx_data_q, tx_byte;
  logic                          busy_q;
  logic                          bip_en;
  logic [15:0]                   nclk_ext;

  // Combinational so a HALT raised mid-run masks the very cycle it appears in.
  assign bip_en = ((state_q == RUN) || (state_q == STEP)) && !bus.i_halt;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nclk_d    = nclk_q;
    acc_d     = acc_q;
    instr_d   = instr_q;
    nclk16_d  = nclk16_q;
    bip_rst_d = 1'b0;
    nclk_ext  = '0;
    if (bip_en && (nclk_q != '1)) nclk_d = nclk_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_done) begin
          case (bus.i_rx_data)
            CMD_RUN:   state_d = RUN;
            CMD_STEP:  state_d = STEP;
            CMD_RESET: begin
              bip_rst_d = 1'b1;
              nclk_d    = '0;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (bus.i_rx_done && (bus.i_rx_data == CMD_RESET)) begin
          bip_rst_d = 1'b1;
          nclk_d    = '0;
          state_d   = IDLE;
        end else if (bus.i_halt) begin
          state_d = TX_SEND;
        end
      end
      STEP:    state_d = TX_SEND;
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = TX_SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot uses nclk_d so the last enabled cycle of a STEP is counted.
    if (((state_q == RUN) || (state_q == STEP)) && (state_d == TX_SEND)) begin
      nclk_ext[LOG2_N_INSMEM_ADDR-1:0] = nclk_d;
      acc_d    = bus.i_acc;
      instr_d  = bus.i_instruction;
      nclk16_d = nclk_ext;
    end

    case (idx_d)
      3'd0:    tx_byte = acc_d[15:8];
      3'd1:    tx_byte = acc_d[7:0];
      3'd2:    tx_byte = instr_d[15:8];
      3'd3:    tx_byte = instr_d[7:0];
      3'd4:    tx_byte = nclk16_d[15:8];
      default: tx_byte = nclk16_d[7:0];
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      nclk_q     <= '0;
      acc_q      <= '0;
      instr_q    <= '0;
      nclk16_q   <= '0;
      bip_rst_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nclk_q     <= nclk_d;
      acc_q      <= acc_d;
      instr_q    <= instr_d;
      nclk16_q   <= nclk16_d;
      bip_rst_q  <= bip_rst_d;
      tx_start_q <= (state_d == TX_SEND);
      busy_q     <= (state_d != IDLE);
      if (state_d == TX_SEND) tx_data_q <= tx_byte;
    end
  end

  assign bus.o_bip_enable = bip_en;
  assign bus.o_bip_rst    = bip_rst_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_nclock     = nclk_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_dbg_state  = state_q;
endmodule
